// File: rtl/mem_burst_loader_if.sv
// Load-channel and memory-bus signal bundle between the TB driver, the burst loader and the memory model.
// Latency: none, wires only.
// Backpressure: valid/ready on the load channel and on the request channel; the response channel carries rsp_ready.
//
// Ports (via modports):
//   master: the loader. Consumes load_valid/cacheline, drives load_ready, masters req_*, accepts rsp_*.
//   slave : the environment. Drives the load channel, accepts requests, returns responses.
interface mem_burst_loader_if #(
    parameter int LINE_WIDTH = 512,
    parameter int ADDR_WIDTH = 26,
    parameter int TAG_WIDTH  = 8
);
    typedef struct packed {
        logic                  rw;
        logic [ADDR_WIDTH-1:0] addr;
        logic [TAG_WIDTH-1:0]  tag;
        logic [LINE_WIDTH-1:0] data;
    } req_data_t;

    typedef struct packed {
        logic [LINE_WIDTH-1:0] data;
        logic [TAG_WIDTH-1:0]  tag;
    } rsp_data_t;

    // load channel (driver -> loader)
    logic                  load_valid;
    logic [LINE_WIDTH-1:0] cacheline;
    logic                  load_ready;

    // memory bus (loader -> memory)
    logic                  req_valid;
    req_data_t             req_data;
    logic                  req_ready;
    logic                  rsp_valid;
    rsp_data_t             rsp_data;
    logic                  rsp_ready;

    modport master (
        input  load_valid, cacheline,
        output load_ready,
        output req_valid, req_data,
        input  req_ready,
        input  rsp_valid, rsp_data,
        output rsp_ready
    );

    modport slave (
        output load_valid, cacheline,
        input  load_ready,
        input  req_valid, req_data,
        output req_ready,
        output rsp_valid, rsp_data,
        input  rsp_ready
    );
endinterface

// File: rtl/mem_burst_loader.sv
// Writes line_count cachelines from the load channel to base_addr.., then optionally reads them back and compares XOR checksums.
// Latency: writes are combinational pass-throughs (0 cycles); done rises the cycle after the last write (no verify) or the last read response.
// Backpressure: load_ready follows req_ready while writing; read issue stalls at MAX_OUTSTANDING in flight; responses always accepted.
//
// Ports: clk, reset_n (async, active-low); start/base_addr/line_count sampled in IDLE or DONE;
//        busy/done/pass status; mem_if.master carries the load channel and the memory bus.
module mem_burst_loader #(
    parameter int LINE_WIDTH      = 512,
    parameter int ADDR_WIDTH      = 26,   // 32-bit byte address, 64-byte lines
    parameter int TAG_WIDTH       = 8,
    parameter int COUNT_WIDTH     = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter bit VERIFY_EN       = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [COUNT_WIDTH-1:0] line_count,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    mem_burst_loader_if.master     mem_if
);
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [COUNT_WIDTH-1:0] ONE     = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] MO_CNT  = COUNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [OW-1:0]          MO_OUT  = OW'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {IDLE, WRITE, RDISSUE, RDDRAIN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [COUNT_WIDTH-1:0]  count_q, wr_idx_q, rd_idx_q, rsp_cnt_q;
    logic [OW-1:0]           outst_q;
    logic [LINE_WIDTH-1:0]   wsum_q, rsum_q, rsum_nxt;
    logic                    pass_q, pass_d;
    logic                    start_acc, wr_fire, rd_fire, rsp_fire;

    always_comb begin
        state_d            = state_q;
        pass_d             = pass_q;
        start_acc          = 1'b0;
        wr_fire            = 1'b0;
        rd_fire            = 1'b0;
        rsp_fire           = 1'b0;
        rsum_nxt           = rsum_q ^ mem_if.rsp_data.data;
        mem_if.load_ready  = 1'b0;
        mem_if.req_valid   = 1'b0;
        mem_if.req_data    = '0;
        mem_if.rsp_ready   = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    start_acc = 1'b1;
                    if (line_count == '0) begin
                        state_d = DONE;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = WRITE;
                        pass_d  = 1'b0;
                    end
                end
            end
            WRITE: begin
                // Straight pass-through: no buffering between driver and bus.
                mem_if.req_valid     = mem_if.load_valid;
                mem_if.load_ready    = mem_if.req_ready;
                mem_if.rsp_ready     = 1'b1;   // writes have no response; drop strays
                mem_if.req_data.rw   = 1'b1;
                mem_if.req_data.addr = base_q + ADDR_WIDTH'(wr_idx_q);
                mem_if.req_data.tag  = TAG_WIDTH'(wr_idx_q);
                mem_if.req_data.data = mem_if.cacheline;
                wr_fire = mem_if.load_valid && mem_if.req_ready;
                if (wr_fire && (wr_idx_q == count_q - ONE)) begin
                    if (VERIFY_EN) begin
                        state_d = RDISSUE;
                    end else begin
                        state_d = DONE;
                        pass_d  = 1'b1;
                    end
                end
            end
            RDISSUE, RDDRAIN: begin
                mem_if.rsp_ready = 1'b1;
                rsp_fire         = mem_if.rsp_valid;
                if (state_q == RDISSUE) begin
                    mem_if.req_valid     = (rd_idx_q < count_q) && (outst_q < MO_OUT);
                    mem_if.req_data.addr = base_q + ADDR_WIDTH'(rd_idx_q);
                    mem_if.req_data.tag  = TAG_WIDTH'(rd_idx_q % MO_CNT);
                    rd_fire = mem_if.req_valid && mem_if.req_ready;
                    if (rd_fire && (rd_idx_q + ONE == count_q)) begin
                        state_d = RDDRAIN;
                    end
                end
                // Every issued read is answered, so the last response implies all reads were issued.
                if (rsp_fire && (rsp_cnt_q + ONE == count_q)) begin
                    state_d = DONE;
                    pass_d  = (rsum_nxt == wsum_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pass_q    <= 1'b0;
            base_q    <= '0;
            count_q   <= '0;
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            rsp_cnt_q <= '0;
            outst_q   <= '0;
            wsum_q    <= '0;
            rsum_q    <= '0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            if (start_acc) begin
                base_q    <= base_addr;
                count_q   <= line_count;
                wr_idx_q  <= '0;
                rd_idx_q  <= '0;
                rsp_cnt_q <= '0;
                outst_q   <= '0;
                wsum_q    <= '0;
                rsum_q    <= '0;
            end else begin
                if (wr_fire) begin
                    wr_idx_q <= wr_idx_q + ONE;
                    wsum_q   <= wsum_q ^ mem_if.cacheline;
                end
                if (rd_fire) begin
                    rd_idx_q <= rd_idx_q + ONE;
                end
                if (rsp_fire) begin
                    rsp_cnt_q <= rsp_cnt_q + ONE;
                    rsum_q    <= rsum_nxt;
                end
                // Issue and response in the same cycle cancel out.
                unique case ({rd_fire, rsp_fire})
                    2'b10:   outst_q <= outst_q + OW'(1);
                    2'b01:   outst_q <= outst_q - OW'(1);
                    default: outst_q <= outst_q;
                endcase
            end
        end
    end

    assign busy = (state_q == WRITE) || (state_q == RDISSUE) || (state_q == RDDRAIN);
    assign done = (state_q == DONE);
    assign pass = pass_q;
endmodule

// File: tb/tb_mem_burst_loader.sv
`timescale 1ns/1ps
module tb_mem_burst_loader;
    localparam int LW = 32, AW = 10, TW = 4, CW = 8, MO = 4, LAT = 6;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic          start_v = 1'b0, start_n = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] line_count = '0;
    logic          busy_v, done_v, pass_v, busy_n, done_n, pass_n;
    logic          load_valid = 1'b0;
    logic [LW-1:0] cacheline = '0;
    logic          req_ready;
    logic          rsp_valid;
    logic [LW-1:0] rsp_dat;
    logic [TW-1:0] rsp_tag;

    mem_burst_loader_if #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) ifv ();
    mem_burst_loader_if #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) ifn ();

    assign ifv.load_valid = load_valid;
    assign ifv.cacheline  = cacheline;
    assign ifv.req_ready  = req_ready;
    assign ifv.rsp_valid  = rsp_valid;
    assign ifv.rsp_data   = {rsp_dat, rsp_tag};
    assign ifn.load_valid = load_valid;
    assign ifn.cacheline  = cacheline;
    assign ifn.req_ready  = req_ready;
    assign ifn.rsp_valid  = 1'b0;
    assign ifn.rsp_data   = '0;

    mem_burst_loader #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .COUNT_WIDTH(CW),
                       .MAX_OUTSTANDING(MO), .VERIFY_EN(1'b1)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start_v), .base_addr(base_addr),
        .line_count(line_count), .busy(busy_v), .done(done_v), .pass(pass_v), .mem_if(ifv));

    mem_burst_loader #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .COUNT_WIDTH(CW),
                       .MAX_OUTSTANDING(MO), .VERIFY_EN(1'b0)) u_nv (
        .clk(clk), .reset_n(reset_n), .start(start_n), .base_addr(base_addr),
        .line_count(line_count), .busy(busy_n), .done(done_n), .pass(pass_n), .mem_if(ifn));

    int vectors = 0, miscompares = 0;
    bit sel = 1'b1;            // 1: verify instance under test, 0: write-only instance
    int rr_mode = 0;           // 0: req_ready high, 1: alternating, 2: random
    int corrupt_idx = -1;      // read index whose returned data gets bit 0 flipped
    int cyc = 0;
    logic [LW-1:0] lines [16];

    // memory model + bus monitors
    logic [LW-1:0] mem [logic [AW-1:0]];
    logic [LW-1:0] pend_d[$];
    int            pend_t[$];
    logic [TW-1:0] pend_tag[$];
    logic [AW-1:0] v_wr_a[$], v_rd_a[$], n_wr_a[$];
    logic [TW-1:0] v_wr_t[$], v_rd_t[$], n_wr_t[$];
    logic [LW-1:0] v_wr_d[$], n_wr_d[$];
    int            n_wr_c[$];
    int            inflight = 0, max_inflight = 0, rd_seen = 0, last_rsp_cyc = -1;

    initial begin : model
        logic [LW-1:0] d;
        rsp_valid = 1'b0; rsp_dat = '0; rsp_tag = '0; req_ready = 1'b1;
        forever begin
            @(posedge clk);
            cyc++;
            if (!reset_n) begin
                pend_d.delete(); pend_t.delete(); pend_tag.delete();
                inflight = 0;
            end else begin
                if (ifn.req_valid && ifn.req_ready) begin
                    n_wr_a.push_back(ifn.req_data.addr);
                    n_wr_t.push_back(ifn.req_data.tag);
                    n_wr_d.push_back(ifn.req_data.data);
                    n_wr_c.push_back(cyc);
                end
                if (ifv.req_valid && ifv.req_ready) begin
                    if (ifv.req_data.rw) begin
                        mem[ifv.req_data.addr] = ifv.req_data.data;
                        v_wr_a.push_back(ifv.req_data.addr);
                        v_wr_t.push_back(ifv.req_data.tag);
                        v_wr_d.push_back(ifv.req_data.data);
                    end else begin
                        d = mem.exists(ifv.req_data.addr) ? mem[ifv.req_data.addr] : '0;
                        if (rd_seen == corrupt_idx) d[0] = ~d[0];
                        pend_d.push_back(d);
                        pend_t.push_back(cyc + LAT);
                        pend_tag.push_back(ifv.req_data.tag);
                        v_rd_a.push_back(ifv.req_data.addr);
                        v_rd_t.push_back(ifv.req_data.tag);
                        rd_seen++;
                        inflight++;
                        if (inflight > max_inflight) max_inflight = inflight;
                    end
                end
                if (ifv.rsp_valid && ifv.rsp_ready && pend_d.size() > 0) begin
                    void'(pend_d.pop_front()); void'(pend_t.pop_front()); void'(pend_tag.pop_front());
                    inflight--;
                    last_rsp_cyc = cyc;
                end
            end
            #1;
            rsp_valid = 1'b0;
            if (reset_n && pend_t.size() > 0) begin
                if (pend_t[0] <= cyc) begin
                    rsp_valid = 1'b1;
                    rsp_dat   = pend_d[0];
                    rsp_tag   = pend_tag[0];
                end
            end
            case (rr_mode)
                0:       req_ready = 1'b1;
                1:       req_ready = cyc[0];
                default: req_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic cur_done();  return sel ? done_v : done_n; endfunction
    function automatic logic cur_pass();  return sel ? pass_v : pass_n; endfunction
    function automatic logic cur_busy();  return sel ? busy_v : busy_n; endfunction
    function automatic logic cur_lr();    return sel ? ifv.load_ready : ifn.load_ready; endfunction
    function automatic logic [63:0] cur_req();
        return sel ? 64'({ifv.req_data.addr, ifv.req_data.data}) : 64'({ifn.req_data.addr, ifn.req_data.data});
    endfunction
    function automatic logic [5:0] outs_v();
        return {busy_v, done_v, pass_v, ifv.req_valid, ifv.load_ready, ifv.rsp_ready};
    endfunction
    function automatic logic [5:0] outs_n();
        return {busy_n, done_n, pass_n, ifn.req_valid, ifn.load_ready, ifn.rsp_ready};
    endfunction

    task automatic clear_logs();
        v_wr_a.delete(); v_wr_t.delete(); v_wr_d.delete(); v_rd_a.delete(); v_rd_t.delete();
        n_wr_a.delete(); n_wr_t.delete(); n_wr_d.delete(); n_wr_c.delete();
        rd_seen = 0; max_inflight = 0; last_rsp_cyc = -1;
        for (int i = 0; i < 16; i++) lines[i] = $urandom;
    endtask

    // called at a negedge; returns at the negedge after the start edge
    task automatic do_start(input logic [AW-1:0] b, input int n);
        base_addr = b; line_count = CW'(n);
        if (sel) start_v = 1'b1; else start_n = 1'b1;
        @(negedge clk);
        start_v = 1'b0; start_n = 1'b0;
    endtask

    // offers lines[0..n-1]; returns at the negedge right after the last accepting edge
    task automatic feed(input int n, input int glitch_at);
        int i = 0, j = 0;
        logic stalled = 1'b0;
        logic [63:0] held = '0;
        while (i < n && j < 400) begin
            load_valid = 1'b1;
            cacheline  = lines[i];
            if (j == glitch_at) begin
                // a start while busy must not disturb the burst
                if (sel) start_v = 1'b1; else start_n = 1'b1;
                base_addr = '0; line_count = CW'(1);
            end else begin
                start_v = 1'b0; start_n = 1'b0;
            end
            #1;
            if (stalled) check("req_stable", cur_req(), held);
            check("load_ready_mirror", 64'(cur_lr()), 64'(req_ready));
            stalled = !cur_lr();
            held    = cur_req();
            if (cur_lr()) i++;
            @(negedge clk);
            j++;
        end
        start_v = 1'b0; start_n = 1'b0;
        load_valid = 1'b0;
        check("feed_complete", 64'(i), 64'(n));
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!cur_done() && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("done_within_budget", 64'(cur_done()), 64'd1);
    endtask

    task automatic check_writes(input logic [AW-1:0] base, input int n);
        logic [AW-1:0] wa[$];
        logic [TW-1:0] wt[$];
        logic [LW-1:0] wd[$];
        logic [AW-1:0] ea;
        wa = sel ? v_wr_a : n_wr_a;
        wt = sel ? v_wr_t : n_wr_t;
        wd = sel ? v_wr_d : n_wr_d;
        check("wr_count", 64'(wa.size()), 64'(n));
        for (int i = 0; i < n && i < wa.size(); i++) begin
            ea = AW'((int'(base) + i) % (1 << AW));
            check($sformatf("wr%0d_addr_tag_data", i), 64'({wa[i], wt[i], wd[i]}),
                  64'({ea, TW'(i % (1 << TW)), lines[i]}));
        end
    endtask

    task automatic check_reads(input logic [AW-1:0] base, input int n);
        logic [AW-1:0] ea;
        check("rd_count", 64'(v_rd_a.size()), 64'(n));
        for (int i = 0; i < n && i < v_rd_a.size(); i++) begin
            ea = AW'((int'(base) + i) % (1 << AW));
            check($sformatf("rd%0d_addr_tag", i), 64'({v_rd_a[i], v_rd_t[i]}), 64'({ea, TW'(i % MO)}));
        end
        check("max_inflight_ok", 64'(max_inflight <= MO), 64'd1);
    endtask

    task automatic run_verify(input logic [AW-1:0] base, input int n, input int mode, input int corrupt);
        sel = 1'b1; rr_mode = mode; corrupt_idx = corrupt;
        clear_logs();
        do_start(base, n);
        feed(n, 2);
        wait_done(300);
        check("v_done_after_last_rsp", 64'(cyc), 64'(last_rsp_cyc));
        check("v_pass", 64'(pass_v), 64'((corrupt < 0 || corrupt >= n) ? 1 : 0));
        check_writes(base, n);
        check_reads(base, n);
    endtask

    initial begin : stim
        logic [AW-1:0] b;
        repeat (3) @(negedge clk);
        check("reset_outs_v", 64'(outs_v()), 64'd0);
        check("reset_outs_n", 64'(outs_n()), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // write-only instance: back-to-back, alternating backpressure, random backpressure with wrap
        for (int t = 0; t < 3; t++) begin
            sel = 1'b0; rr_mode = t; corrupt_idx = -1;
            b = (t == 2) ? AW'(10'h3FE) : AW'(10'h100);
            @(negedge clk);
            clear_logs();
            do_start(b, 4);
            check($sformatf("nv%0d_busy_after_start", t), 64'(cur_busy()), 64'd1);
            feed(4, (t == 1) ? 1 : -1);
            check($sformatf("nv%0d_done_next_cycle", t), 64'(done_n), 64'd1);
            check($sformatf("nv%0d_pass", t), 64'(pass_n), 64'd1);
            check($sformatf("nv%0d_done_cyc", t), 64'(cyc), 64'(n_wr_c.size() > 0 ? n_wr_c[$] : -1));
            if (t == 0)
                check("nv_back_to_back", 64'(n_wr_c.size() == 4 ? n_wr_c[3] - n_wr_c[0] : -1), 64'd3);
            repeat (3) @(negedge clk);
            check_writes(b, 4);
        end

        // verify instance
        run_verify(AW'($urandom_range(0, 1000)), 8, 0, -1);
        run_verify(AW'($urandom_range(0, 1000)), 8, 2, 5);
        run_verify(AW'(10'h3FE), 4, 2, -1);
        run_verify(AW'($urandom_range(0, 1000)), 6, 1, -1);

        // zero-length burst
        sel = 1'b1;
        clear_logs();
        do_start(AW'(10'h55), 0);
        check("zero_outs", 64'({done_v, pass_v, busy_v}), 64'b110);
        repeat (5) @(negedge clk);
        check("zero_no_traffic", 64'(v_wr_a.size() + v_rd_a.size()), 64'd0);

        // reset in the middle of a write burst, then restart
        rr_mode = 0; corrupt_idx = -1;
        clear_logs();
        do_start(AW'(10'h40), 8);
        feed(3, -1);
        check("pre_reset_busy", 64'(busy_v), 64'd1);
        reset_n = 1'b0;
        #1;
        check("mid_reset_outs_v", 64'(outs_v()), 64'd0);
        @(negedge clk);
        check("reset_held_outs_v", 64'(outs_v()), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        clear_logs();
        do_start(AW'(10'h20), 2);
        feed(2, -1);
        wait_done(100);
        check("restart_pass", 64'(pass_v), 64'd1);
        check_writes(AW'(10'h20), 2);
        check_reads(AW'(10'h20), 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
